// File: rtl/kgp_arb_pkg.sv
// rtl/kgp_arb_pkg.sv - shared types and constants for the memory port arbiter
package kgp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int WAIT_MAX = 15;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - 4-bit loadable down-counter with zero flag
module arb_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    // Saturates at zero so an idle decrement never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared memory port
// Optional macro ARB_ROUND_ROBIN_EN: ties go to the requester that did not own last.
module mem_port_arbiter
    import kgp_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_sel,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        if_gnt,
    output logic        dm_gnt,
    output logic        if_done,
    output logic        dm_done,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES - 1);

    arb_state_t  state, state_nxt;
    logic        owner_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        winner;
    logic        start;
    logic        capture;
    logic        cnt_zero;

`ifdef ARB_ROUND_ROBIN_EN
    // Only the tie-break reads the previous owner, so it exists only in this build.
    logic last_owner_q;

    always_comb begin
        winner = dm_req ? OWN_DM : OWN_IF;
        if (if_req && dm_req) begin
            winner = ~last_owner_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWN_IF;
        end else if (start) begin
            last_owner_q <= winner;
        end
    end
`else
    always_comb begin
        winner = dm_req ? OWN_DM : OWN_IF;
    end
`endif

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    start     = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_zero) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            owner_q <= OWN_IF;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (start) begin
                owner_q <= winner;
                addr_q  <= (winner == OWN_DM) ? dm_addr : if_addr;
                we_q    <= (winner == OWN_DM) && dm_we;
                wdata_q <= (winner == OWN_DM) ? dm_wdata : 32'd0;
            end
            if (capture) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    arb_wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (LOAD_VAL),
        .dec      (state == ST_ACCESS),
        .zero     (cnt_zero)
    );

    // Memory-side outputs are forced low outside ACCESS so nothing leaks while idle.
    assign busy      = (state != ST_IDLE);
    assign if_gnt    = (state == ST_ACCESS) && (owner_q == OWN_IF);
    assign dm_gnt    = (state == ST_ACCESS) && (owner_q == OWN_DM);
    assign if_done   = (state == ST_DONE) && (owner_q == OWN_IF);
    assign dm_done   = (state == ST_DONE) && (owner_q == OWN_DM);
    assign mem_sel   = (state == ST_ACCESS) && owner_q;
    assign mem_we    = (state == ST_ACCESS) && we_q;
    assign mem_addr  = (state == ST_ACCESS) ? addr_q : 32'd0;
    assign mem_wdata = (state == ST_ACCESS) ? wdata_q : 32'd0;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter at WAIT_CYCLES 2 and 1
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        mem_sel [2];
    logic        mem_we  [2];
    logic        if_gnt  [2];
    logic        dm_gnt  [2];
    logic        if_done [2];
    logic        dm_done [2];
    logic        busy    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] rdata     [2];

    int checks = 0;
    int errors = 0;
    int wc [2] = '{2, 1};

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_port_arbiter #(.WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .mem_rdata(mem_rdata), .mem_sel(mem_sel[0]), .mem_addr(mem_addr[0]),
        .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]), .if_gnt(if_gnt[0]),
        .dm_gnt(dm_gnt[0]), .if_done(if_done[0]), .dm_done(dm_done[0]),
        .rdata(rdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .mem_rdata(mem_rdata), .mem_sel(mem_sel[1]), .mem_addr(mem_addr[1]),
        .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]), .if_gnt(if_gnt[1]),
        .dm_gnt(dm_gnt[1]), .if_done(if_done[1]), .dm_done(dm_done[1]),
        .rdata(rdata[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction model: t counts cycles left in the transaction (W grant cycles then done).
    int          t [2] = '{0, 0};
    logic        m_own   [2];
    logic        m_last  [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];

    function automatic logic pick(input logic last);
        if (if_req && dm_req) return RR ? ~last : 1'b1;
        return dm_req;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                t[d]       <= 0;
                m_own[d]   <= 1'b0;
                m_last[d]  <= 1'b0;
                m_we[d]    <= 1'b0;
                m_rdata[d] <= 32'd0;
            end else if (t[d] == 0) begin
                if (if_req || dm_req) begin
                    m_own[d]   <= pick(m_last[d]);
                    m_last[d]  <= pick(m_last[d]);
                    m_addr[d]  <= pick(m_last[d]) ? dm_addr : if_addr;
                    m_we[d]    <= pick(m_last[d]) & dm_we;
                    m_wdata[d] <= pick(m_last[d]) ? dm_wdata : 32'd0;
                    t[d]       <= wc[d] + 1;
                end
            end else begin
                if (t[d] == 2) m_rdata[d] <= mem_rdata;
                t[d] <= t[d] - 1;
            end
        end
    end

    function automatic logic acc(input int d);
        return t[d] >= 2;
    endfunction

    function automatic logic dn(input int d);
        return t[d] == 1;
    endfunction

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d busy", d),    32'(busy[d]),    32'(t[d] != 0));
                chk($sformatf("d%0d if_gnt", d),  32'(if_gnt[d]),  32'(acc(d) && !m_own[d]));
                chk($sformatf("d%0d dm_gnt", d),  32'(dm_gnt[d]),  32'(acc(d) && m_own[d]));
                chk($sformatf("d%0d if_done", d), 32'(if_done[d]), 32'(dn(d) && !m_own[d]));
                chk($sformatf("d%0d dm_done", d), 32'(dm_done[d]), 32'(dn(d) && m_own[d]));
                chk($sformatf("d%0d mem_we", d),  32'(mem_we[d]),  32'(acc(d) && m_we[d]));
                if (acc(d)) begin
                    chk($sformatf("d%0d mem_sel", d),   32'(mem_sel[d]), 32'(m_own[d]));
                    chk($sformatf("d%0d mem_addr", d),  mem_addr[d],     m_addr[d]);
                    chk($sformatf("d%0d mem_wdata", d), mem_wdata[d],    m_wdata[d]);
                end
                if (dn(d) && !m_we[d]) begin
                    chk($sformatf("d%0d rdata", d), rdata[d], m_rdata[d]);
                end
            end
        end
    end

    logic exp_order [4];
    int   got, we_cyc, seen, ndone;

    initial begin
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0; mem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset busy",     32'(busy[d]),    32'd0);
            chk("reset gnts",     32'(if_gnt[d] | dm_gnt[d]), 32'd0);
            chk("reset mem_we",   32'(mem_we[d]),  32'd0);
            chk("reset rdata",    rdata[d],        32'd0);
            chk("reset mem_addr", mem_addr[d],     32'd0);
        end
        rst = 1'b0;

        // Single fetch, cycle 0 is the sampling cycle.
        if_addr = 32'h0000_0040; if_req = 1'b1;
        @(negedge clk);
        chk("fetch c1 if_gnt",   32'(if_gnt[0]),  32'd1);
        chk("fetch c1 mem_sel",  32'(mem_sel[0]), 32'd0);
        chk("fetch c1 mem_addr", mem_addr[0],     32'h40);
        chk("w1 c1 if_gnt",      32'(if_gnt[1]),  32'd1);
        @(negedge clk);
        chk("fetch c2 if_gnt",   32'(if_gnt[0]),  32'd1);
        chk("w1 c2 if_gnt",      32'(if_gnt[1]),  32'd0);
        chk("w1 c2 if_done",     32'(if_done[1]), 32'd1);
        chk("w1 c2 rdata",       rdata[1],        32'hDEAD_BEEF);
        @(negedge clk);
        chk("fetch c3 if_done",  32'(if_done[0]), 32'd1);
        chk("fetch c3 rdata",    rdata[0],        32'hDEAD_BEEF);
        chk("fetch c3 if_gnt",   32'(if_gnt[0]),  32'd0);
        chk("w1 c3 idle gap",    32'(busy[1]),    32'd0);
        @(negedge clk);
        chk("w1 c4 regrant",     32'(if_gnt[1]),  32'd1);
        chk("fetch c4 idle",     32'(busy[0]),    32'd0);
        if_req = 1'b0;
        repeat (4) @(negedge clk);

        // Store.
        mem_rdata = 32'h0BAD_F00D;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h1234_5678;
        we_cyc = 0; seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (mem_we[0]) begin
                we_cyc++;
                chk("store mem_sel",   32'(mem_sel[0]), 32'd1);
                chk("store mem_addr",  mem_addr[0],     32'h100);
                chk("store mem_wdata", mem_wdata[0],    32'h1234_5678);
            end
            if (dm_done[0]) begin
                seen = 1;
                chk("store mem_we in done", 32'(mem_we[0]), 32'd0);
            end
        end
        chk("store done seen", 32'(seen), 32'd1);
        chk("store we cycles", 32'(we_cyc), 32'd2);
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        chk("store done single pulse", 32'(dm_done[0]), 32'd0);
        repeat (3) @(negedge clk);

        // Tie: both held across four transactions from a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (RR) exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        else    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
        mem_rdata = 32'h55AA_55AA; if_addr = 32'h200; dm_addr = 32'h300;
        if_req = 1'b1; dm_req = 1'b1;
        got = 0;
        for (int k = 0; k < 60 && got < 4; k++) begin
            @(negedge clk);
            if (if_done[0] || dm_done[0]) begin
                chk($sformatf("tie order %0d", got), 32'(dm_done[0]), 32'(exp_order[got]));
                got++;
            end
        end
        chk("tie transactions", 32'(got), 32'd4);
        if_req = 1'b0; dm_req = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during the second ACCESS cycle.
        if_addr = 32'h44; if_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort pre gnt", 32'(if_gnt[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort busy",     32'(busy[0]),    32'd0);
        chk("abort if_gnt",   32'(if_gnt[0]),  32'd0);
        chk("abort mem_addr", mem_addr[0],     32'd0);
        chk("abort done",     32'(if_done[0] | if_done[1]), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (if_done[0]) ndone++;
        end
        chk("abort no done", 32'(ndone), 32'd0);
        dm_addr = 32'h300; dm_req = 1'b1;
        @(negedge clk);
        chk("post reset dm_gnt",   32'(dm_gnt[0]), 32'd1);
        chk("post reset mem_addr", mem_addr[0],    32'h300);
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (dm_done[0]) seen = 1;
        end
        chk("post reset done", 32'(seen), 32'd1);
        dm_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, memory access latency in cycles (legal range 1..15).
REQ-002 Port clk  input  1  single clock, all state on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port if_req  input  1  instruction-fetch request, held high until if_done.
REQ-005 Port if_addr  input  32  fetch address.
REQ-006 Port dm_req  input  1  data-memory request, held high until dm_done.
REQ-007 Port dm_we  input  1  data request is a store when high.
REQ-008 Port dm_addr  input  32  data address.
REQ-009 Port dm_wdata  input  32  store data.
REQ-010 Port mem_rdata  input  32  read data returned by the shared memory.
REQ-011 Port mem_sel  output  1  address-mux select: 0 = fetch, 1 = data.
REQ-012 Port mem_addr  output  32  address to the shared memory.
REQ-013 Port mem_we  output  1  memory write enable.
REQ-014 Port mem_wdata  output  32  memory write data.
REQ-015 Port if_gnt / dm_gnt  output  1 each  requester owns the port.
REQ-016 Port if_done / dm_done  output  1 each  one-cycle completion pulse.
REQ-017 Port rdata  output  32  registered read data, valid while *_done is high.
REQ-018 Port busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, ACCESS, DONE; all outputs registered or decoded from registered state.
REQ-020 IDLE: if any request is sampled high, latch the winner's owner, address, we and wdata, load the counter with WAIT_CYCLES-1, and go to ACCESS.
REQ-021 IDLE with no request: stay in IDLE, all grants and mem_we low.
REQ-022 ACCESS: the owner's gnt is high, mem_sel equals owner, and mem_addr, mem_we and mem_wdata hold the latched values. The counter decrements each cycle.
REQ-023 ACCESS with counter zero: capture mem_rdata into rdata and go to DONE.
REQ-024 DONE: assert the owner's done for exactly one cycle, deassert the grant and mem_we, and go to IDLE.
REQ-025 Latency: a request sampled in IDLE at cycle N gives grant during N+1..N+WAIT_CYCLES and done at N+WAIT_CYCLES+1.
REQ-026 Back-to-back: there is always one IDLE cycle between transactions.
REQ-027 Store transactions also pulse done; rdata is don't-care for stores.
REQ-028 A requester dropping req mid-ACCESS does not abort the transaction; done still pulses.
REQ-029 Requests that arrive while busy are ignored until IDLE.
REQ-030 Register last_owner is updated to the owner on every grant.

Reset
REQ-031 rst forces IDLE immediately, aborting any in-flight access.
REQ-032 During and after rst, all outputs are 0, the counter is 0, and last_owner = fetch.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN. When defined, simultaneous if_req and dm_req are granted to the requester other than last_owner.
REQ-034 Without ARB_ROUND_ROBIN_EN, simultaneous requests always grant data (fixed data priority). A single request is granted in both modes.

Structure
REQ-035 Package kgp_arb_pkg holds the FSM state typedef, the owner encoding (OWN_IF=0, OWN_DM=1) and the WAIT_CYCLES upper bound.
REQ-036 Sub-module arb_wait_counter holds the 4-bit loadable down-counter with a zero flag.

Verification
REQ-037 Single fetch: WAIT_CYCLES=2, if_req at cycle 0, if_addr=0x0000_0040, mem_rdata=0xDEAD_BEEF.
  -> if_gnt high on cycles 1-2, mem_sel=0, mem_addr=0x40; if_done and rdata=0xDEADBEEF on cycle 3.
REQ-038 Store: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0x1234_5678.
  -> mem_sel=1, mem_we=1 for WAIT_CYCLES cycles; dm_done pulses once; mem_we low in DONE.
REQ-039 Tie, fixed priority: both requests held for 3 transactions (macro off).
  -> grant order DM, DM, DM.
REQ-040 Tie, round robin: both requests held for 4 transactions (macro on).
  -> grant order DM, IF, DM, IF.
REQ-041 Reset mid-access: rst asserted during the 2nd ACCESS cycle.
  -> all outputs 0 asynchronously; no done pulse; the next request is granted normally.
REQ-042 Boundary: WAIT_CYCLES=1, single fetch.
  -> grant for exactly 1 cycle; done on cycle 2; then an IDLE cycle before the next grant.
